pen_param_ctrl: RTL

Button-sequencing controller for the drawing-settings datapath: it owns the shared up/down/mode push-buttons and arbitrates them between two setting registers, pen colour (3-bit) and brush size (2-bit). Each raw button is synchronised and debounced, converted to a press event, and auto-repeated while held. A mode button selects which register the up/down events step. It sits between the board buttons and the OLED drawing/cursor logic and replaces per-register button handling.

---
 rtl/pen_param_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 46 ++++
 rtl/pen_param_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pen_param_pkg.sv
// Shared types and constants for the pen/brush button-sequencing controller.
package pen_param_pkg;

  typedef enum logic {
    MODE_COLOR = 1'b0,
    MODE_BRUSH = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  localparam logic [2:0] COLOR_RST = 3'd4;
  localparam logic [1:0] BRUSH_RST = 2'd1;
  localparam logic [2:0] COLOR_MAX = 3'd7;
  localparam logic [1:0] BRUSH_MAX = 2'd3;

  // Saturating +/-1 on the colour index; ends are sticky, no wrap.
  function automatic logic [2:0] color_step(input logic [2:0] c, input logic up);
    if (up) return (c == COLOR_MAX) ? c : c + 3'd1;
    else    return (c == 3'd0)      ? c : c - 3'd1;
  endfunction

  function automatic logic [1:0] brush_step(input logic [1:0] b, input logic up);
    if (up) return (b == BRUSH_MAX) ? b : b + 2'd1;
    else    return (b == 2'd0)      ? b : b - 2'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-sample debouncer; press is the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic          level_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level_q    <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      level_prev <= level_q;
      if (sync2 == level_q) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // This edge is the DEBOUNCE_CYC-th differing sample.
        level_q <= ~level_q;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_prev;

endmodule

// File: rtl/pen_param_ctrl.sv
// Arbitrates shared up/down/mode buttons between pen colour and brush size,
// with press-to-step and held-button auto-repeat.
module pen_param_ctrl
  import pen_param_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  input  logic       cursor_sw,
  output logic       mode,
  output logic [2:0] color,
  output logic [1:0] brush,
  output logic       step_strobe
);

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic deb_up, deb_down, deb_mode;
  logic press_up, press_down, press_mode;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up), .level(deb_up), .press(press_up)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
    .clk(clk), .reset(reset), .raw(btn_down), .level(deb_down), .press(press_down)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .reset(reset), .raw(btn_mode), .level(deb_mode), .press(press_mode)
  );

  rep_state_e    state;
  dir_e          cur_dir;
  dir_e          req_dir;
  mode_e         mode_q;
  logic [RW-1:0] rep_cnt;
  logic          start;
  logic          do_step;
  logic          cnt_done;

  always_comb begin
    req_dir = DIR_NONE;
    if (deb_up && !deb_down)      req_dir = DIR_UP;
    else if (deb_down && !deb_up) req_dir = DIR_DOWN;
  end

  assign start    = (press_up && req_dir == DIR_UP) || (press_down && req_dir == DIR_DOWN);
  assign cnt_done = (rep_cnt == RW'(1));

  // A repeat step needs the same direction still held; any change drops to IDLE.
  always_comb begin
    do_step = 1'b0;
    if (!cursor_sw) begin
      case (state)
        IDLE:          do_step = start;
        DELAY, REPEAT: do_step = (req_dir == cur_dir) && cnt_done;
        default:       do_step = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_dir     <= DIR_NONE;
      rep_cnt     <= '0;
      mode_q      <= MODE_COLOR;
      color       <= COLOR_RST;
      brush       <= BRUSH_RST;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= do_step;
      // Step uses the pre-toggle mode, so a coincident mode press hits the old target.
      if (do_step) begin
        if (mode_q == MODE_COLOR) color <= color_step(color, req_dir == DIR_UP);
        else                      brush <= brush_step(brush, req_dir == DIR_UP);
      end

      if (cursor_sw) begin
        state <= IDLE;
      end else if (press_mode) begin
        mode_q <= (mode_q == MODE_COLOR) ? MODE_BRUSH : MODE_COLOR;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= DELAY;
              cur_dir <= req_dir;
              rep_cnt <= RW'(REPEAT_DELAY);
            end
          end
          DELAY, REPEAT: begin
            if (req_dir != cur_dir) begin
              state <= IDLE;
            end else if (cnt_done) begin
              state   <= REPEAT;
              rep_cnt <= RW'(REPEAT_RATE);
            end else begin
              rep_cnt <= rep_cnt - RW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mode = mode_q;

endmodule
